// File: rtl/cpu_flit_assembler_pkg.sv
// Shared flit types, counter type and the checksum helper used by the flit assembler.
package types;

    typedef struct packed {
        logic [7:0]   chk;
        logic [119:0] payload;
    } flit_t;

    localparam int FLIT_W = $bits(flit_t);

    typedef logic [7:0] cnt8_t;

    // Returns the flit with its checksum field replaced by the XOR of the payload bytes.
    function automatic flit_t calculate_checksum_comb(input flit_t raw);
        flit_t       f;
        logic [7:0]  x;
        f = raw;
        x = '0;
        for (int i = 0; i < 15; i++) begin
            x = x ^ raw.payload[i*8 +: 8];
        end
        f.chk = x;
        return f;
    endfunction

    function automatic cnt8_t sat_inc(input cnt8_t c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/cpu_flit_assembler_if.sv
// CPU beat input and NoC flit output handshakes of the flit assembler.
interface cpu_flit_assembler_if #(
    parameter int CPU_W = 32
);
    import types::*;

    logic [CPU_W-1:0] data_in;
    logic             data_in_vld;
    logic             data_in_rdy;
    flit_t            pushed_flit;
    logic             pushed_flit_valid;
    logic             pushed_flit_ready;

    modport slave (
        input  data_in, data_in_vld, pushed_flit_ready,
        output data_in_rdy, pushed_flit, pushed_flit_valid
    );

    modport master (
        output data_in, data_in_vld, pushed_flit_ready,
        input  data_in_rdy, pushed_flit, pushed_flit_valid
    );
endinterface

// File: rtl/cpu_flit_assembler_fifo.sv
// First-word-fall-through flit FIFO; head is forced to zero while empty.
module flit_sync_fifo
    import types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  flit_t                  push_data,
    input  logic                   pop,
    output flit_t                  pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    flit_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = empty ? '0 : mem[rd_ptr_q];
endmodule

// File: rtl/cpu_flit_assembler.sv
// Packs CPU beats into flits, drops flits with a bad checksum and queues good ones for the NoC.
module cpu_flit_assembler
    import types::*;
#(
    parameter int CPU_W        = 32,
    parameter int FLIT_DEPTH   = 4,
    parameter bit STRICT_BURST = 1'b1
) (
    input  logic                 nocclk,
    input  logic                 rst_n,
    cpu_flit_assembler_if.slave  bus,
    input  logic                 sys_err_clear,
    output logic                 sys_invalid_flit,
    output cnt8_t                err_count,
    output cnt8_t                abort_count
);
    localparam int BEATS = FLIT_W / CPU_W;
    localparam int PW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(FLIT_DEPTH) + 1;

    logic [PW-1:0]     pos_q, pos_d;
    logic [FLIT_W-1:0] raw_q, raw_d;
    logic              complete_q, complete_d;
    logic              invalid_q, invalid_d;
    cnt8_t             err_q, err_d, abort_q, abort_d;

    logic              rdy, accept, abort_evt, chk_ok, push, bad_flit, pop;
    flit_t             corrected, fifo_head;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;

    // A flit awaiting its check already owns a FIFO slot, so it is counted here.
    assign rdy    = rst_n & ~fifo_full & ((fifo_count + CW'(complete_q)) < CW'(FLIT_DEPTH));
    assign accept = bus.data_in_vld & rdy;

    always_comb begin
        pos_d      = pos_q;
        raw_d      = raw_q;
        complete_d = 1'b0;
        abort_evt  = 1'b0;
        if (accept) begin
            raw_d[pos_q*CPU_W +: CPU_W] = bus.data_in;
            if (pos_q == PW'(BEATS-1)) begin
                pos_d      = '0;
                complete_d = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end else if (STRICT_BURST && !bus.data_in_vld && pos_q != '0) begin
            pos_d     = '0;
            abort_evt = 1'b1;
        end
    end

    assign corrected = calculate_checksum_comb(flit_t'(raw_q));
    assign chk_ok    = (corrected == flit_t'(raw_q));
    assign push      = complete_q & chk_ok;
    assign bad_flit  = complete_q & ~chk_ok;

    // A fresh event in the same cycle as a clear leaves the count at one.
    always_comb begin
        invalid_d = invalid_q;
        err_d     = err_q;
        abort_d   = abort_q;
        if (sys_err_clear) begin
            invalid_d = 1'b0;
            err_d     = '0;
            abort_d   = '0;
        end
        if (bad_flit) begin
            invalid_d = 1'b1;
            err_d     = sys_err_clear ? 8'd1 : sat_inc(err_q);
        end
        if (abort_evt) begin
            abort_d = sys_err_clear ? 8'd1 : sat_inc(abort_q);
        end
    end

    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            raw_q      <= '0;
            complete_q <= 1'b0;
            invalid_q  <= 1'b0;
            err_q      <= '0;
            abort_q    <= '0;
        end else begin
            pos_q      <= pos_d;
            raw_q      <= raw_d;
            complete_q <= complete_d;
            invalid_q  <= invalid_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    assign pop = ~fifo_empty & bus.pushed_flit_ready;

    flit_sync_fifo #(.DEPTH(FLIT_DEPTH)) u_fifo (
        .clk       (nocclk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (corrected),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.data_in_rdy       = rdy;
    assign bus.pushed_flit       = fifo_head;
    assign bus.pushed_flit_valid = ~fifo_empty;
    assign sys_invalid_flit      = invalid_q;
    assign err_count             = err_q;
    assign abort_count           = abort_q;
endmodule
